// File: rtl/counter_rate_sequencer_if.sv
// Control/status bundle between the board buttons/switches and the rate
// sequencer. The master side drives buttons and switches; the slave side is
// the sequencer, which returns the counter strobes and its status.
interface counter_rate_sequencer_if;
  logic [1:0] rate_sel;
  logic       mode;
  logic       start_btn;
  logic       stop_btn;
  logic       step_btn;
  logic       clear_btn;
  logic       count_en;
  logic       count_clr;
  logic [1:0] state;
  logic [1:0] active_rate;

  modport master (
    output rate_sel, mode, start_btn, stop_btn, step_btn, clear_btn,
    input  count_en, count_clr, state, active_rate
  );

  modport slave (
    input  rate_sel, mode, start_btn, stop_btn, step_btn, clear_btn,
    output count_en, count_clr, state, active_rate
  );
endinterface

// File: rtl/counter_rate_sequencer.sv
// counter_rate_sequencer: drives a fast-clocked up-counter with one-cycle
// count-enable / clear strobes at a switch-selected rate. Buttons provide
// run, pause, single-step, one-shot (2^CNT_WIDTH enables) and clear.
module counter_rate_sequencer #(
  parameter int DIV_WIDTH = 27,
  parameter int TICK0     = 12500000,
  parameter int TICK1     = 25000000,
  parameter int TICK2     = 50000000,
  parameter int TICK3     = 100000000,
  parameter int CNT_WIDTH = 3
) (
  input logic                     clk,
  input logic                     rst,
  counter_rate_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PAUSE   = 2'b10,
    ONESHOT = 2'b11
  } state_t;

  localparam logic [DIV_WIDTH-1:0] LAST0 = DIV_WIDTH'(TICK0 - 1);
  localparam logic [DIV_WIDTH-1:0] LAST1 = DIV_WIDTH'(TICK1 - 1);
  localparam logic [DIV_WIDTH-1:0] LAST2 = DIV_WIDTH'(TICK2 - 1);
  localparam logic [DIV_WIDTH-1:0] LAST3 = DIV_WIDTH'(TICK3 - 1);
  // Pulse count value just before the final one-shot enable.
  localparam logic [CNT_WIDTH:0]   PULSE_LAST = (CNT_WIDTH + 1)'((1 << CNT_WIDTH) - 1);

  // Button vectors are ordered {clear, stop, start, step}.
  logic [1:0]           rate_s1, rate_s2;
  logic                 mode_s1, mode_s2;
  logic [3:0]           btn_s1, btn_s2, btn_s3;
  logic                 clear_edge, stop_edge, start_edge, step_edge;
  logic                 running, tick;
  logic [DIV_WIDTH-1:0] div_last;

  state_t               state;
  logic [DIV_WIDTH-1:0] div;
  logic [CNT_WIDTH:0]   pulse_cnt;
  logic [1:0]           active_rate;
  logic                 count_en;
  logic                 count_clr;

  // Two-flop synchronizers for switches and buttons, plus an edge-detect stage on buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate_s1 <= '0;
      rate_s2 <= '0;
      mode_s1 <= 1'b0;
      mode_s2 <= 1'b0;
      btn_s1  <= '0;
      btn_s2  <= '0;
      btn_s3  <= '0;
    end else begin
      // NOTE: non-blocking so each stage samples the previous stage's old value; blocking would collapse the chain into one flop.
      rate_s1 <= bus.rate_sel;
      rate_s2 <= rate_s1;
      mode_s1 <= bus.mode;
      mode_s2 <= mode_s1;
      btn_s1  <= {bus.clear_btn, bus.stop_btn, bus.start_btn, bus.step_btn};
      btn_s2  <= btn_s1;
      btn_s3  <= btn_s2;
    end
  end

  // Rising-edge strobes, terminal divider value for the applied rate, and the tick.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    div_last   = LAST0;
    clear_edge = btn_s2[3] & ~btn_s3[3];
    stop_edge  = btn_s2[2] & ~btn_s3[2];
    start_edge = btn_s2[1] & ~btn_s3[1];
    step_edge  = btn_s2[0] & ~btn_s3[0];
    case (active_rate)
      2'd1:    div_last = LAST1;
      2'd2:    div_last = LAST2;
      2'd3:    div_last = LAST3;
      default: div_last = LAST0;
    endcase
    running = (state == RUN) || (state == ONESHOT);
    tick    = running && (div == div_last);
  end

  // Sequencer FSM with divider, pulse count, applied rate and registered strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      div         <= '0;
      pulse_cnt   <= '0;
      active_rate <= 2'd0;
      count_en    <= 1'b0;
      count_clr   <= 1'b0;
    end else begin
      count_en  <= 1'b0;
      count_clr <= 1'b0;

      // Rate follows the switches while stopped; while counting it only changes on a tick.
      if (!running || (tick && !clear_edge)) begin
        active_rate <= rate_s2;
      end

      if (clear_edge) begin
        // Clear wins over everything, including a tick in the same cycle.
        count_clr <= 1'b1;
        state     <= IDLE;
        div       <= '0;
        pulse_cnt <= '0;
      end else begin
        if (tick) begin
          count_en <= 1'b1;
          div      <= '0;
        end else if (running) begin
          div <= div + 1'b1;
        end else begin
          div <= '0;
        end

        case (state)
          IDLE: begin
            if (!stop_edge) begin
              if (start_edge) begin
                state     <= mode_s2 ? ONESHOT : RUN;
                pulse_cnt <= '0;
              end else if (step_edge) begin
                count_en <= 1'b1;
              end
            end
          end
          RUN: begin
            if (stop_edge) begin
              state <= PAUSE;
              div   <= '0;
            end
          end
          PAUSE: begin
            if (stop_edge) begin
              state <= IDLE;
            end else if (start_edge) begin
              state <= RUN;
              div   <= '0;
            end else if (step_edge) begin
              count_en <= 1'b1;
            end
          end
          ONESHOT: begin
            if (tick) begin
              pulse_cnt <= pulse_cnt + 1'b1;
            end
            if (stop_edge || (tick && (pulse_cnt == PULSE_LAST))) begin
              state <= IDLE;
              div   <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.count_en    = count_en;
  assign bus.count_clr   = count_clr;
  assign bus.state       = state;
  assign bus.active_rate = active_rate;

endmodule
